reg_native_if_arb2: RTL and testbench

REG_NATIVE_IF_ARB2 -- requirements
Module: reg_native_if_arb2

---
 rtl/reg_native_if_arb2_pkg.sv | 16 +
 rtl/reg_native_if_rr_pick2.sv | 21 ++
 rtl/reg_native_if_arb2.sv | 199 +++++++++++++++++++
 tb/tb_reg_native_if_arb2.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_native_if_arb2_pkg.sv
// Shared types for the two-port native-if arbiter: FSM state encoding and grant index.
package reg_native_if_arb2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef logic gnt_idx_t;

  // Reset value of last_grant: pointing at s1 lets s0 win the first contention.
  localparam gnt_idx_t GNT_RESET = 1'b1;

endpackage

// File: rtl/reg_native_if_rr_pick2.sv
// Two-way round-robin pick, purely combinational; zero latency, no backpressure.
module reg_native_if_rr_pick2
  import reg_native_if_arb2_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_idx_t   last_grant,
  output logic       gnt_vld,
  output gnt_idx_t   gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    case (req)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_native_if_arb2.sv
// Round-robin 2:1 native-if arbiter, one transaction in flight; m_req_vld 1 cycle after grant, sN_ack 1 cycle after m_ack.
// Requesters hold req_vld until ack; optional WAIT timeout enabled by REG_NATIVE_IF_ARB2_TIMEOUT_EN.
module reg_native_if_arb2 #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_req_vld,
  input  logic                  s0_wr_en,
  input  logic                  s0_rd_en,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_wr_data,
  output logic                  s0_ack_vld,
  output logic [DATA_WIDTH-1:0] s0_rd_data,
  output logic                  s0_err,
  input  logic                  s1_req_vld,
  input  logic                  s1_wr_en,
  input  logic                  s1_rd_en,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_wr_data,
  output logic                  s1_ack_vld,
  output logic [DATA_WIDTH-1:0] s1_rd_data,
  output logic                  s1_err,
  output logic                  m_req_vld,
  output logic                  m_wr_en,
  output logic                  m_rd_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wr_data,
  input  logic                  m_ack_vld,
  input  logic [DATA_WIDTH-1:0] m_rd_data,
  input  logic                  m_err
);
  import reg_native_if_arb2_pkg::*;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  gnt_idx_t              last_grant_q, last_grant_d;
  gnt_idx_t              gnt_q, gnt_d;
  logic                  m_req_vld_q, m_req_vld_d;
  logic                  m_wr_en_q, m_wr_en_d;
  logic                  m_rd_en_q, m_rd_en_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wr_data_q, m_wr_data_d;
  logic                  s0_ack_vld_q, s0_ack_vld_d, s1_ack_vld_q, s1_ack_vld_d;
  logic [DATA_WIDTH-1:0] s0_rd_data_q, s0_rd_data_d, s1_rd_data_q, s1_rd_data_d;
  logic                  s0_err_q, s0_err_d, s1_err_q, s1_err_d;

  logic                  pick_vld;
  gnt_idx_t              pick_idx;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

`ifdef REG_NATIVE_IF_ARB2_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  reg_native_if_rr_pick2 u_pick (
    .req        ({s1_req_vld, s0_req_vld}),
    .last_grant (last_grant_q),
    .gnt_vld    (pick_vld),
    .gnt_idx    (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    m_req_vld_d  = 1'b0;
    m_wr_en_d    = m_wr_en_q;
    m_rd_en_d    = m_rd_en_q;
    m_addr_d     = m_addr_q;
    m_wr_data_d  = m_wr_data_q;
    s0_ack_vld_d = 1'b0;
    s0_rd_data_d = '0;
    s0_err_d     = 1'b0;
    s1_ack_vld_d = 1'b0;
    s1_rd_data_d = '0;
    s1_err_d     = 1'b0;
    rsp_vld      = 1'b0;
    rsp_data     = '0;
    rsp_err      = 1'b0;
`ifdef REG_NATIVE_IF_ARB2_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d        = pick_idx;
          last_grant_d = pick_idx;
          m_req_vld_d  = 1'b1;
          m_wr_en_d    = pick_idx ? s1_wr_en   : s0_wr_en;
          m_rd_en_d    = pick_idx ? s1_rd_en   : s0_rd_en;
          m_addr_d     = pick_idx ? s1_addr    : s0_addr;
          m_wr_data_d  = pick_idx ? s1_wr_data : s0_wr_data;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef REG_NATIVE_IF_ARB2_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // A real ack always takes priority over an expiring timeout.
        if (m_ack_vld) begin
          rsp_vld  = 1'b1;
          rsp_data = m_rd_data;
          rsp_err  = m_err;
`ifdef REG_NATIVE_IF_ARB2_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          rsp_vld  = 1'b1;
          rsp_err  = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
`endif
        end
        if (rsp_vld) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Response registers are loaded on the WAIT->RESP edge so the ack pulse lands in RESP.
    if (rsp_vld) begin
      if (gnt_q) begin
        s1_ack_vld_d = 1'b1;
        s1_rd_data_d = rsp_data;
        s1_err_d     = rsp_err;
      end else begin
        s0_ack_vld_d = 1'b1;
        s0_rd_data_d = rsp_data;
        s0_err_d     = rsp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_RESET;
      gnt_q        <= 1'b0;
      m_req_vld_q  <= 1'b0;
      m_wr_en_q    <= 1'b0;
      m_rd_en_q    <= 1'b0;
      m_addr_q     <= '0;
      m_wr_data_q  <= '0;
      s0_ack_vld_q <= 1'b0;
      s0_rd_data_q <= '0;
      s0_err_q     <= 1'b0;
      s1_ack_vld_q <= 1'b0;
      s1_rd_data_q <= '0;
      s1_err_q     <= 1'b0;
`ifdef REG_NATIVE_IF_ARB2_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      m_req_vld_q  <= m_req_vld_d;
      m_wr_en_q    <= m_wr_en_d;
      m_rd_en_q    <= m_rd_en_d;
      m_addr_q     <= m_addr_d;
      m_wr_data_q  <= m_wr_data_d;
      s0_ack_vld_q <= s0_ack_vld_d;
      s0_rd_data_q <= s0_rd_data_d;
      s0_err_q     <= s0_err_d;
      s1_ack_vld_q <= s1_ack_vld_d;
      s1_rd_data_q <= s1_rd_data_d;
      s1_err_q     <= s1_err_d;
`ifdef REG_NATIVE_IF_ARB2_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign m_req_vld  = m_req_vld_q;
  assign m_wr_en    = m_wr_en_q;
  assign m_rd_en    = m_rd_en_q;
  assign m_addr     = m_addr_q;
  assign m_wr_data  = m_wr_data_q;
  assign s0_ack_vld = s0_ack_vld_q;
  assign s0_rd_data = s0_rd_data_q;
  assign s0_err     = s0_err_q;
  assign s1_ack_vld = s1_ack_vld_q;
  assign s1_rd_data = s1_rd_data_q;
  assign s1_err     = s1_err_q;

endmodule

// File: tb/tb_reg_native_if_arb2.sv
// Scoreboard bench for reg_native_if_arb2: downstream requests and upstream acks are queued at drive time.
// Timeout scenario is built when REG_NATIVE_IF_ARB2_TIMEOUT_EN is defined.
module tb_reg_native_if_arb2;

`ifdef REG_NATIVE_IF_ARB2_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_req_vld = 1'b0, s0_wr_en = 1'b0, s0_rd_en = 1'b0;
  logic [63:0] s0_addr = '0;
  logic [31:0] s0_wr_data = '0;
  logic        s0_ack_vld, s0_err;
  logic [31:0] s0_rd_data;
  logic        s1_req_vld = 1'b0, s1_wr_en = 1'b0, s1_rd_en = 1'b0;
  logic [63:0] s1_addr = '0;
  logic [31:0] s1_wr_data = '0;
  logic        s1_ack_vld, s1_err;
  logic [31:0] s1_rd_data;
  logic        m_req_vld, m_wr_en, m_rd_en;
  logic [63:0] m_addr;
  logic [31:0] m_wr_data;
  logic        m_ack_vld = 1'b0;
  logic [31:0] m_rd_data = '0;
  logic        m_err = 1'b0;

  reg_native_if_arb2 #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s0_req_vld(s0_req_vld), .s0_wr_en(s0_wr_en), .s0_rd_en(s0_rd_en), .s0_addr(s0_addr),
    .s0_wr_data(s0_wr_data), .s0_ack_vld(s0_ack_vld), .s0_rd_data(s0_rd_data), .s0_err(s0_err),
    .s1_req_vld(s1_req_vld), .s1_wr_en(s1_wr_en), .s1_rd_en(s1_rd_en), .s1_addr(s1_addr),
    .s1_wr_data(s1_wr_data), .s1_ack_vld(s1_ack_vld), .s1_rd_data(s1_rd_data), .s1_err(s1_err),
    .m_req_vld(m_req_vld), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_ack_vld(m_ack_vld), .m_rd_data(m_rd_data), .m_err(m_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; bit rd; logic [63:0] addr; logic [31:0] data; } mreq_t;
  typedef struct { bit port; logic [31:0] rd; bit err; int lat; } ack_t;

  mreq_t exp_m[$];
  ack_t  exp_ack[$];

  int vec = 0;
  int miscmp = 0;
  int cyc = 0;
  int req_cyc[2];
  int n_ack = 0;
  bit prev_mreq = 1'b0;

  // Downstream responder configuration (written by the main sequence only).
  bit          rsp_en = 1'b1;
  int          rsp_dly = 1;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  int          pulse_cnt = 0;
  int          pulse_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Single driver of m_ack_vld: either a response to m_req_vld or a stray pulse requested by the sequence.
  always begin
    @(negedge clk);
    m_ack_vld = 1'b0;
    if (pulse_cnt != pulse_done) begin
      pulse_done = pulse_cnt;
      m_ack_vld  = 1'b1;
      m_rd_data  = rsp_data;
      m_err      = rsp_err;
    end else if (m_req_vld && rsp_en) begin
      repeat (rsp_dly) @(negedge clk);
      m_ack_vld = 1'b1;
      m_rd_data = rsp_data;
      m_err     = rsp_err;
    end
  end

  always @(negedge clk) begin : mon
    mreq_t       e;
    ack_t        a;
    logic [31:0] rd_a, rd_o;
    logic        err_a, err_o;
    if (prev_mreq) chk("m_req_pulse", 64'(m_req_vld), 64'd0);
    prev_mreq = m_req_vld;
    if (m_req_vld) begin
      if (exp_m.size() == 0) chk("m_req_unexpected", 64'(m_req_vld), 64'd0);
      else begin
        e = exp_m.pop_front();
        chk("m_wr_en", 64'(m_wr_en), 64'(e.wr));
        chk("m_rd_en", 64'(m_rd_en), 64'(e.rd));
        chk("m_addr", m_addr, e.addr);
        chk("m_wr_data", 64'(m_wr_data), 64'(e.data));
      end
    end
    if (s0_ack_vld || s1_ack_vld) begin
      n_ack++;
      if (exp_ack.size() == 0) chk("ack_unexpected", 64'({s1_ack_vld, s0_ack_vld}), 64'd0);
      else begin
        a = exp_ack.pop_front();
        rd_a  = a.port ? s1_rd_data : s0_rd_data;
        err_a = a.port ? s1_err : s0_err;
        rd_o  = a.port ? s0_rd_data : s1_rd_data;
        err_o = a.port ? s0_err : s1_err;
        chk("ack_port", 64'({s1_ack_vld, s0_ack_vld}), a.port ? 64'd2 : 64'd1);
        chk("ack_rd_data", 64'(rd_a), 64'(a.rd));
        chk("ack_err", 64'(err_a), 64'(a.err));
        chk("other_port_quiet", 64'({err_o, rd_o}), 64'd0);
        if (a.lat >= 0) chk("ack_latency", 64'(cyc - req_cyc[a.port]), 64'(a.lat));
      end
    end
  end

  task automatic drive(input bit port, input bit wr, input bit rd, input logic [63:0] addr,
                       input logic [31:0] wd, input bit want_ack, input int lat);
    mreq_t m;
    ack_t  a;
    m = '{wr, rd, addr, wd};
    exp_m.push_back(m);
    if (want_ack) begin
      a = '{port, rsp_data, rsp_err, lat};
      exp_ack.push_back(a);
    end
    req_cyc[port] = cyc;
    if (port) begin
      s1_req_vld = 1'b1; s1_wr_en = wr; s1_rd_en = rd; s1_addr = addr; s1_wr_data = wd;
    end else begin
      s0_req_vld = 1'b1; s0_wr_en = wr; s0_rd_en = rd; s0_addr = addr; s0_wr_data = wd;
    end
  endtask

  // Requesters release req_vld on the cycle they see their ack.
  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_m.size() != 0 || exp_ack.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
      if (s0_ack_vld) s0_req_vld = 1'b0;
      if (s1_ack_vld) s1_req_vld = 1'b0;
    end
    chk("drain_pending", 64'(exp_m.size() + exp_ack.size()), 64'd0);
    exp_m.delete();
    exp_ack.delete();
    @(negedge clk);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_m_ctl"}, 64'({m_req_vld, m_wr_en, m_rd_en}), 64'd0);
    chk({tag, "_m_addr"}, m_addr, 64'd0);
    chk({tag, "_m_data"}, 64'(m_wr_data), 64'd0);
    chk({tag, "_s_ctl"}, 64'({s0_ack_vld, s0_err, s1_ack_vld, s1_err}), 64'd0);
    chk({tag, "_s_rd"}, {s0_rd_data, s1_rd_data}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst_check("reset");
    rst = 1'b0;
    @(negedge clk);

    // Contention from reset: s0 first, then alternating.
    rsp_dly = 1; rsp_data = 32'h5555_AAAA; rsp_err = 1'b0;
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h100 + 64'(r), 32'h1100 + 32'(r), 1'b1, -1);
      drive(1'b1, 1'b0, 1'b1, 64'h200 + 64'(r), 32'h2200 + 32'(r), 1'b1, -1);
      wait_drain(100);
    end

    // s0 write, ack two cycles after m_req_vld.
    rsp_dly = 2; rsp_data = 32'h1234_5678; rsp_err = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 64'h10, 32'hA5A5_A5A5, 1'b1, 4);
    wait_drain(100);

    // s1 read with error, minimum latency.
    rsp_dly = 1; rsp_data = 32'hDEAD_BEEF; rsp_err = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 64'h20, 32'h0, 1'b1, 3);
    wait_drain(100);

    // Both enables high is forwarded unchanged.
    rsp_data = 32'h0BAD_F00D; rsp_err = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 64'hFFFF_0000_0000_0030, 32'h7777_8888, 1'b1, 3);
    wait_drain(100);

    // Requester drops req_vld during WAIT; ack still arrives. Both enables low.
    rsp_dly = 3; rsp_data = 32'h0000_00C3;
    drive(1'b1, 1'b0, 1'b0, 64'h48, 32'h0, 1'b1, 5);
    repeat (2) @(negedge clk);
    s1_req_vld = 1'b0;
    wait_drain(100);

    // Reset during WAIT abandons the transaction; a later ack is ignored.
    rsp_en = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 64'h30, 32'h0, 1'b0, -1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s0_req_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rst_check("midrst");
    n0 = n_ack;
    pulse_cnt++;
    repeat (5) @(negedge clk);
    chk("ack_after_rst", 64'(n_ack - n0), 64'd0);
    rst_check("post_pulse");
    exp_m.delete();
    rsp_en = 1'b1;

    // last_grant is back at its reset value: s0 wins again.
    rsp_dly = 1; rsp_data = 32'h0F0F_0F0F;
    drive(1'b1, 1'b1, 1'b0, 64'h300, 32'h3300, 1'b0, -1);
    s1_req_vld = 1'b0;
    exp_m.delete();
    drive(1'b0, 1'b1, 1'b0, 64'h400, 32'h4400, 1'b1, -1);
    drive(1'b1, 1'b1, 1'b0, 64'h300, 32'h3300, 1'b1, -1);
    wait_drain(100);

`ifdef REG_NATIVE_IF_ARB2_TIMEOUT_EN
    // No downstream ack: timeout after TO WAIT cycles with err=1, rd_data=0.
    rsp_en = 1'b0; rsp_data = 32'h0; rsp_err = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 64'h50, 32'h0, 1'b1, 2 + TO);
    wait_drain(100);
    rsp_data = 32'hFFFF_FFFF; rsp_err = 1'b0;
    n0 = n_ack;
    pulse_cnt++;
    repeat (5) @(negedge clk);
    chk("late_ack_ignored", 64'(n_ack - n0), 64'd0);
`else
    // Without the timeout, WAIT holds well past TIMEOUT_CYCLES until an ack comes.
    rsp_en = 1'b0; rsp_data = 32'hCAFE_F00D; rsp_err = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 64'h50, 32'h0, 1'b1, -1);
    n0 = n_ack;
    repeat (300) @(negedge clk);
    chk("wait_holds", 64'(n_ack - n0), 64'd0);
    pulse_cnt++;
    wait_drain(20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
